fir_sequencer: RTL and testbench

Sequences the 64-tap FIR datapath for one audio channel. Owns the 64-entry sample ring buffer, the newest-sample offset and the coefficient-bank select. Issues the one-cycle start pulse to the FIR, waits out its fixed compute latency, and captures its result with a valid strobe. Sits between the sample source (decimator/ADC front end) and the FIR; one instance per FIR.

---
 rtl/fir_pkg.sv | 41 ++++
 rtl/sample_ring.sv | 45 ++++
 rtl/fir_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fir_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared constants, types and helpers for the FIR sequencer slice.
//            TAPS           - ring depth / FIR tap count
//            SAMPLE_W       - audio sample width
//            OFFSET_W       - width of the newest-sample offset
//            BANK_W         - coefficient bank select width
//            RESULT_LATENCY - default FIR compute latency in cycles
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int TAPS           = 64;
    localparam int SAMPLE_W       = 16;
    localparam int OFFSET_W       = 6;
    localparam int BANK_W         = 2;
    localparam int RESULT_LATENCY = 65;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Advance a ring index, wrapping from depth-1 back to 0. Written as an
    // explicit compare so non-power-of-two depths also wrap correctly.
    function automatic logic [OFFSET_W-1:0] ring_next(
        input logic [OFFSET_W-1:0] ptr,
        input int                  depth
    );
        if (int'(ptr) == depth - 1) begin
            return '0;
        end
        return ptr + OFFSET_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_ring.sv
`default_nettype none
// ============================================================================
// Module   : sample_ring
// Purpose  : TAPS-deep register array of audio samples with a wrapping write
//            pointer. One sample is written per write-enable; rst clears
//            every entry and the pointer.
// Ports    : clk        - clock
//            rst        - synchronous active-high clear
//            i_wr_en    - write i_wr_data at o_wr_ptr, then advance pointer
//            i_wr_data  - sample to store
//            o_ring     - full ring contents
//            o_wr_ptr   - index the next write will land on
// Revision : 1.0 - initial release
// ============================================================================
module sample_ring #(
    // Must not exceed 2**OFFSET_W so the pointer can address every entry.
    parameter int TAPS = fir_pkg::TAPS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_wr_en,
    input  fir_pkg::sample_t                    i_wr_data,
    output fir_pkg::sample_t [TAPS-1:0]         o_ring,
    output logic [fir_pkg::OFFSET_W-1:0]        o_wr_ptr
);
    import fir_pkg::*;

    sample_t [TAPS-1:0]   r_ring;
    logic [OFFSET_W-1:0]  r_wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ring   <= '0;
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_ring[r_wr_ptr] <= i_wr_data;
            r_wr_ptr         <= ring_next(r_wr_ptr, TAPS);
        end
    end

    assign o_ring   = r_ring;
    assign o_wr_ptr = r_wr_ptr;

endmodule
`default_nettype wire

// File: rtl/fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_sequencer
// Purpose  : Sequences one 64-tap FIR for a single audio channel. Stores
//            incoming samples in a ring, launches the FIR with a one-cycle
//            start pulse, waits out its fixed latency and captures the result.
//            A one-deep pending register absorbs a sample arriving while a
//            run is in flight; further arrivals are dropped and flagged.
// Ports    : clk_in / rst_in      - clock, synchronous active-high reset
//            sample_in            - new audio sample
//            sample_valid_in      - single-cycle sample strobe
//            bank_sel_in          - coefficient bank request, latched at start
//            fir_sample_out       - ring contents to the FIR sample array
//            fir_offset_out       - index of the newest sample in the ring
//            fir_bank_out         - latched coefficient bank
//            fir_ready_out        - one-cycle FIR start pulse
//            fir_result_in        - FIR output
//            signal_out           - captured filter output (held)
//            signal_valid_out     - one-cycle pulse on capture
//            busy_out             - high while a run is in flight
//            overrun_out          - sticky sample-dropped flag
//            overrun_clear_in     - clears overrun_out (a new drop wins)
// Revision : 1.0 - initial release
// ============================================================================
module fir_sequencer #(
    parameter int TAPS           = fir_pkg::TAPS,
    parameter int RESULT_LATENCY = fir_pkg::RESULT_LATENCY
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  fir_pkg::sample_t                    sample_in,
    input  logic                                sample_valid_in,
    input  logic [fir_pkg::BANK_W-1:0]          bank_sel_in,
    output fir_pkg::sample_t [TAPS-1:0]         fir_sample_out,
    output logic [fir_pkg::OFFSET_W-1:0]        fir_offset_out,
    output logic [fir_pkg::BANK_W-1:0]          fir_bank_out,
    output logic                                fir_ready_out,
    input  fir_pkg::sample_t                    fir_result_in,
    output fir_pkg::sample_t                    signal_out,
    output logic                                signal_valid_out,
    output logic                                busy_out,
    output logic                                overrun_out,
    input  logic                                overrun_clear_in
);
    import fir_pkg::*;

    // Counter runs 0..RESULT_LATENCY-1 in RUN.
    localparam int                 C_CNT_W    = $clog2(RESULT_LATENCY + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(RESULT_LATENCY - 1);

    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_pend_full;
    sample_t              r_pend_data;
    logic [OFFSET_W-1:0]  r_offset;
    logic [BANK_W-1:0]    r_bank;
    logic                 r_ready;
    sample_t              r_signal;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_overrun;

    logic                 w_start;
    sample_t              w_start_data;
    logic                 w_drop;
    logic [OFFSET_W-1:0]  w_wr_ptr;

    // A run starts from IDLE whenever a sample is available; a queued sample
    // always goes first so arrival order is preserved.
    always_comb begin
        w_start      = 1'b0;
        w_start_data = sample_in;
        w_drop       = 1'b0;
        if (r_state == IDLE) begin
            w_start      = r_pend_full | sample_valid_in;
            w_start_data = r_pend_full ? r_pend_data : sample_in;
        end else begin
            w_drop = sample_valid_in & r_pend_full;
        end
    end

    sample_ring #(
        .TAPS (TAPS)
    ) u_ring (
        .clk       (clk_in),
        .rst       (rst_in),
        .i_wr_en   (w_start),
        .i_wr_data (w_start_data),
        .o_ring    (fir_sample_out),
        .o_wr_ptr  (w_wr_ptr)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pend_full <= 1'b0;
            r_pend_data <= '0;
            r_offset    <= '0;
            r_bank      <= '0;
            r_ready     <= 1'b0;
            r_signal    <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_offset <= w_wr_ptr;
                        r_bank   <= bank_sel_in;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= START;
                    end
                end
                START: begin
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_signal <= fir_result_in;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Pending register. In IDLE a full entry is consumed by the start
            // above; a sample arriving in that same cycle refills it. Outside
            // IDLE the entry is filled once and further arrivals are dropped.
            if (r_state == IDLE) begin
                if (r_pend_full) begin
                    if (sample_valid_in) begin
                        r_pend_data <= sample_in;
                    end else begin
                        r_pend_full <= 1'b0;
                    end
                end
            end else if (sample_valid_in && !r_pend_full) begin
                r_pend_data <= sample_in;
                r_pend_full <= 1'b1;
            end

            // A new drop takes priority over a clear in the same cycle.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clear_in) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign fir_offset_out   = r_offset;
    assign fir_bank_out     = r_bank;
    assign fir_ready_out    = r_ready;
    assign signal_out       = r_signal;
    assign signal_valid_out = r_valid;
    assign busy_out         = r_busy;
    assign overrun_out      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_sequencer
// Purpose  : Directed self-checking bench for fir_sequencer. Cycle "A" is the
//            cycle in which sample_valid_in is high and the sample is taken.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_sequencer;
    import fir_pkg::*;

    logic                  clk_in = 1'b0;
    logic                  rst_in;
    sample_t               sample_in;
    logic                  sample_valid_in;
    logic [BANK_W-1:0]     bank_sel_in;
    sample_t [TAPS-1:0]    fir_sample_out;
    logic [OFFSET_W-1:0]   fir_offset_out;
    logic [BANK_W-1:0]     fir_bank_out;
    logic                  fir_ready_out;
    sample_t               fir_result_in;
    sample_t               signal_out;
    logic                  signal_valid_out;
    logic                  busy_out;
    logic                  overrun_out;
    logic                  overrun_clear_in;

    int vectors     = 0;
    int miscompares = 0;

    fir_sequencer #(
        .TAPS           (TAPS),
        .RESULT_LATENCY (RESULT_LATENCY)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .bank_sel_in      (bank_sel_in),
        .fir_sample_out   (fir_sample_out),
        .fir_offset_out   (fir_offset_out),
        .fir_bank_out     (fir_bank_out),
        .fir_ready_out    (fir_ready_out),
        .fir_result_in    (fir_result_in),
        .signal_out       (signal_out),
        .signal_valid_out (signal_valid_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out),
        .overrun_clear_in (overrun_clear_in)
    );

    always #5 clk_in = ~clk_in;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        rst_in           = 1'b1;
        sample_valid_in  = 1'b0;
        sample_in        = '0;
        bank_sel_in      = '0;
        fir_result_in    = '0;
        overrun_clear_in = 1'b0;
        ticks(2);
        rst_in = 1'b0;
    endtask

    // Issue one sample in cycle A and return in cycle A+67 (back in IDLE).
    task automatic send_run(input sample_t v);
        sample_in       = v;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        ticks(66);
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (fir_ready_out !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0b expected 0", fir_ready_out); end
        vectors++; if (signal_out !== 16'sh0000) begin miscompares++; $display("FAIL reset_signal: got %h expected 0000", signal_out); end
        vectors++; if (signal_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", signal_valid_out); end
        vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy_out); end
        vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %0b expected 0", overrun_out); end
        vectors++; if (fir_offset_out !== 6'd0) begin miscompares++; $display("FAIL reset_offset: got %0d expected 0", fir_offset_out); end
        vectors++; if (fir_bank_out !== 2'd0) begin miscompares++; $display("FAIL reset_bank: got %0d expected 0", fir_bank_out); end
        vectors++; if (fir_sample_out !== '0) begin miscompares++; $display("FAIL reset_ring: ring not all zero"); end
    endtask

    task automatic test_one_sample();
        int rdy_cnt = 0;
        int vld_cnt = 0;
        apply_reset();
        sample_in       = 16'sh1234;
        sample_valid_in = 1'b1;
        tick();                                  // A+1
        sample_valid_in = 1'b0;
        vectors++; if (fir_ready_out !== 1'b1) begin miscompares++; $display("FAIL one_ready: got %0b expected 1", fir_ready_out); end
        vectors++; if (busy_out !== 1'b1) begin miscompares++; $display("FAIL one_busy: got %0b expected 1", busy_out); end
        vectors++; if (fir_offset_out !== 6'd0) begin miscompares++; $display("FAIL one_offset: got %0d expected 0", fir_offset_out); end
        vectors++; if (fir_sample_out[0] !== 16'sh1234) begin miscompares++; $display("FAIL one_ring0: got %h expected 1234", fir_sample_out[0]); end
        for (int i = 0; i < 65; i++) begin       // A+2 .. A+66
            tick();
            rdy_cnt += int'(fir_ready_out);
            vld_cnt += int'(signal_valid_out);
        end
        fir_result_in = 16'sh00AB;               // present only in A+66
        tick();                                  // A+67
        fir_result_in = '0;
        vectors++; if (rdy_cnt != 0) begin miscompares++; $display("FAIL one_extra_ready: got %0d pulses expected 0", rdy_cnt); end
        vectors++; if (vld_cnt != 0) begin miscompares++; $display("FAIL one_early_valid: got %0d pulses expected 0", vld_cnt); end
        vectors++; if (signal_valid_out !== 1'b1) begin miscompares++; $display("FAIL one_valid: got %0b expected 1", signal_valid_out); end
        vectors++; if (signal_out !== 16'sh00AB) begin miscompares++; $display("FAIL one_result: got %h expected 00ab", signal_out); end
        vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL one_busy_done: got %0b expected 0", busy_out); end
        tick();                                  // A+68
        vectors++; if (signal_valid_out !== 1'b0) begin miscompares++; $display("FAIL one_valid_pulse: got %0b expected 0", signal_valid_out); end
        vectors++; if (signal_out !== 16'sh00AB) begin miscompares++; $display("FAIL one_result_hold: got %h expected 00ab", signal_out); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 1; k <= 64; k++) send_run(sample_t'(k));
        vectors++; if (fir_offset_out !== 6'd63) begin miscompares++; $display("FAIL wrap_offset63: got %0d expected 63", fir_offset_out); end
        vectors++; if (fir_sample_out[63] !== 16'sh0040) begin miscompares++; $display("FAIL wrap_ring63: got %h expected 0040", fir_sample_out[63]); end
        send_run(16'sh0041);
        vectors++; if (fir_offset_out !== 6'd0) begin miscompares++; $display("FAIL wrap_offset0: got %0d expected 0", fir_offset_out); end
        vectors++; if (fir_sample_out[0] !== 16'sh0041) begin miscompares++; $display("FAIL wrap_ring0: got %h expected 0041", fir_sample_out[0]); end
        vectors++; if (fir_sample_out[1] !== 16'sh0002) begin miscompares++; $display("FAIL wrap_ring1: got %h expected 0002", fir_sample_out[1]); end
    endtask

    task automatic test_busy_arrival();
        apply_reset();
        sample_in       = 16'sh0A0A;
        sample_valid_in = 1'b1;
        tick();                                  // A+1
        sample_valid_in = 1'b0;
        ticks(11);                               // A+12: RUN count 10
        sample_in       = 16'sh0B0B;
        sample_valid_in = 1'b1;
        tick();                                  // A+13
        sample_valid_in = 1'b0;
        ticks(54);                               // A+67
        vectors++; if (signal_valid_out !== 1'b1) begin miscompares++; $display("FAIL busy_first_valid: got %0b expected 1", signal_valid_out); end
        vectors++; if (fir_ready_out !== 1'b0) begin miscompares++; $display("FAIL busy_ready_early: got %0b expected 0", fir_ready_out); end
        tick();                                  // A+68
        vectors++; if (fir_ready_out !== 1'b1) begin miscompares++; $display("FAIL busy_pend_ready: got %0b expected 1", fir_ready_out); end
        vectors++; if (fir_offset_out !== 6'd1) begin miscompares++; $display("FAIL busy_pend_offset: got %0d expected 1", fir_offset_out); end
        vectors++; if (fir_sample_out[1] !== 16'sh0B0B) begin miscompares++; $display("FAIL busy_pend_ring1: got %h expected 0b0b", fir_sample_out[1]); end
        vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL busy_no_overrun: got %0b expected 0", overrun_out); end
        ticks(66);                               // A+134
        vectors++; if (signal_valid_out !== 1'b1) begin miscompares++; $display("FAIL busy_second_valid: got %0b expected 1", signal_valid_out); end
    endtask

    task automatic test_overrun();
        apply_reset();
        sample_in       = 16'sh1111;
        sample_valid_in = 1'b1;
        tick();                                  // A+1
        sample_valid_in = 1'b0;
        ticks(4);                                // A+5
        sample_in       = 16'sh2222;
        sample_valid_in = 1'b1;
        tick();                                  // A+6
        sample_valid_in = 1'b0;
        vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL ovr_second_ok: got %0b expected 0", overrun_out); end
        ticks(4);                                // A+10
        sample_in       = 16'sh3333;
        sample_valid_in = 1'b1;
        tick();                                  // A+11
        sample_valid_in = 1'b0;
        vectors++; if (overrun_out !== 1'b1) begin miscompares++; $display("FAIL ovr_set: got %0b expected 1", overrun_out); end
        overrun_clear_in = 1'b1;
        tick();                                  // A+12
        overrun_clear_in = 1'b0;
        vectors++; if (overrun_out !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %0b expected 0", overrun_out); end
        sample_in        = 16'sh4444;
        sample_valid_in  = 1'b1;
        overrun_clear_in = 1'b1;
        tick();                                  // A+13
        sample_valid_in  = 1'b0;
        overrun_clear_in = 1'b0;
        vectors++; if (overrun_out !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins: got %0b expected 1", overrun_out); end
        ticks(55);                               // A+68
        vectors++; if (fir_ready_out !== 1'b1) begin miscompares++; $display("FAIL ovr_pend_ready: got %0b expected 1", fir_ready_out); end
        vectors++; if (fir_sample_out[1] !== 16'sh2222) begin miscompares++; $display("FAIL ovr_pend_ring1: got %h expected 2222", fir_sample_out[1]); end
        ticks(67);                               // A+135
        vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL ovr_idle_after: got %0b expected 0", busy_out); end
        vectors++; if (fir_offset_out !== 6'd1) begin miscompares++; $display("FAIL ovr_no_third: got offset %0d expected 1", fir_offset_out); end
    endtask

    task automatic test_bank_latch();
        apply_reset();
        bank_sel_in     = 2'd2;
        sample_in       = 16'sh0123;
        sample_valid_in = 1'b1;
        tick();                                  // A+1
        sample_valid_in = 1'b0;
        bank_sel_in     = 2'd1;
        vectors++; if (fir_bank_out !== 2'd2) begin miscompares++; $display("FAIL bank_latch: got %0d expected 2", fir_bank_out); end
        ticks(30);
        vectors++; if (fir_bank_out !== 2'd2) begin miscompares++; $display("FAIL bank_run_hold: got %0d expected 2", fir_bank_out); end
        ticks(36);                               // A+67, IDLE
        vectors++; if (fir_bank_out !== 2'd2) begin miscompares++; $display("FAIL bank_idle_hold: got %0d expected 2", fir_bank_out); end
        sample_valid_in = 1'b1;
        tick();                                  // A+68
        sample_valid_in = 1'b0;
        vectors++; if (fir_bank_out !== 2'd1) begin miscompares++; $display("FAIL bank_next_start: got %0d expected 1", fir_bank_out); end
        ticks(66);
    endtask

    task automatic test_reset_mid_run();
        int vld_cnt = 0;
        apply_reset();
        bank_sel_in   = 2'd3;
        fir_result_in = 16'sh7777;
        send_run(16'sh5555);                     // B: signal_out now 7777
        sample_in       = 16'sh6666;
        sample_valid_in = 1'b1;
        tick();                                  // B+1
        sample_valid_in = 1'b0;
        ticks(31);                               // B+32: RUN count 30
        rst_in = 1'b1;
        tick();                                  // B+33
        rst_in = 1'b0;
        vectors++; if (signal_out !== 16'sh0000) begin miscompares++; $display("FAIL mid_signal: got %h expected 0000", signal_out); end
        vectors++; if (busy_out !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %0b expected 0", busy_out); end
        vectors++; if (fir_offset_out !== 6'd0) begin miscompares++; $display("FAIL mid_offset: got %0d expected 0", fir_offset_out); end
        vectors++; if (fir_bank_out !== 2'd0) begin miscompares++; $display("FAIL mid_bank: got %0d expected 0", fir_bank_out); end
        vectors++; if (fir_sample_out[1] !== 16'sh0000) begin miscompares++; $display("FAIL mid_ring1: got %h expected 0000", fir_sample_out[1]); end
        bank_sel_in = 2'd0;
        for (int i = 0; i < 70; i++) begin
            tick();
            vld_cnt += int'(signal_valid_out);
        end
        vectors++; if (vld_cnt != 0) begin miscompares++; $display("FAIL mid_no_valid: got %0d pulses expected 0", vld_cnt); end
        sample_in       = 16'sh0BCD;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        vectors++; if (fir_sample_out[0] !== 16'sh0BCD) begin miscompares++; $display("FAIL mid_next_ring0: got %h expected 0bcd", fir_sample_out[0]); end
        vectors++; if (fir_offset_out !== 6'd0) begin miscompares++; $display("FAIL mid_next_offset: got %0d expected 0", fir_offset_out); end
    endtask

    initial begin
        rst_in           = 1'b1;
        sample_in        = '0;
        sample_valid_in  = 1'b0;
        bank_sel_in      = '0;
        fir_result_in    = '0;
        overrun_clear_in = 1'b0;
        test_reset();
        test_one_sample();
        test_wrap();
        test_busy_arrival();
        test_overrun();
        test_bank_latch();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
